uart_nic_arbiter: RTL and testbench

Shares one UART_CONTROLLER between two OS-side clients (client 0, client 1), e.g. two UART_OS_simulator_binary instances.
- TX: each client gets a 1-byte holding buffer, and the buffers are drained to the controller with round-robin arbitration.
- RX: received bytes are routed to client 0, client 1, both, or dropped, per rx_route, with a per-client valid/ack handshake.
- Sits between the OS simulators and UART_CONTROLLER in UART_main-level tops.

---
 rtl/uart_nic_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_nic_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_nic_arbiter.sv
// rtl/uart_nic_arbiter.sv - shares one UART controller between two clients: round-robin TX holding buffers, routed RX delivery
module uart_nic_arbiter #(
  parameter int TX_HOLDOFF = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_wr,
  input  logic [DATA_W-1:0] c0_data,
  output logic              c0_busy,
  output logic              c0_ovf,
  input  logic              c1_wr,
  input  logic [DATA_W-1:0] c1_data,
  output logic              c1_busy,
  output logic              c1_ovf,
  output logic              c0_rx_valid,
  output logic              c1_rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              c0_rx_ack,
  input  logic              c1_rx_ack,
  input  logic [1:0]        rx_route,
  output logic [7:0]        rx_drop_cnt,
  output logic [DATA_W-1:0] nic_data_in,
  output logic              nic_write,
  input  logic              nic_tx_ready,
  input  logic [DATA_W-1:0] nic_data_out,
  input  logic              nic_rx_i,
  output logic              nic_read
);

  localparam int HOLD_W = (TX_HOLDOFF > 1) ? $clog2(TX_HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TX_HOLDOFF - 1);

  typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_HOLD} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DELIVER, R_WAIT} rx_state_t;

  tx_state_t         tx_state, tx_next;
  rx_state_t         rx_state, rx_next;
  logic [DATA_W-1:0] c0_buf, c1_buf;
  logic              rr_ptr;
  logic              grant;
  logic              grant_next;
  logic              tx_start;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rx_capture;
  logic [1:0]        route_q;
  logic              c0_valid_next, c1_valid_next;

  // TX holding buffers; a write into a full buffer only raises the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      c0_busy <= 1'b0;
      c1_busy <= 1'b0;
      c0_ovf  <= 1'b0;
      c1_ovf  <= 1'b0;
      c0_buf  <= '0;
      c1_buf  <= '0;
    end else begin
      if (tx_state == T_ISSUE && !grant) c0_busy <= 1'b0;
      if (tx_state == T_ISSUE && grant)  c1_busy <= 1'b0;
      if (c0_wr) begin
        if (c0_busy) begin
          c0_ovf <= 1'b1;
        end else begin
          c0_buf  <= c0_data;
          c0_busy <= 1'b1;
        end
      end
      if (c1_wr) begin
        if (c1_busy) begin
          c1_ovf <= 1'b1;
        end else begin
          c1_buf  <= c1_data;
          c1_busy <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_next    = tx_state;
    tx_start   = 1'b0;
    nic_write  = 1'b0;
    grant_next = (c0_busy && c1_busy) ? rr_ptr : c1_busy;
    case (tx_state)
      T_IDLE: begin
        if (nic_tx_ready && (c0_busy || c1_busy)) begin
          tx_start = 1'b1;
          tx_next  = T_ISSUE;
        end
      end
      T_ISSUE: begin
        nic_write = 1'b1;
        tx_next   = T_HOLD;
      end
      T_HOLD: begin
        if (hold_cnt == HOLD_LAST) tx_next = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // nic_data_in is loaded at grant time and held until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= T_IDLE;
      rr_ptr      <= 1'b0;
      grant       <= 1'b0;
      hold_cnt    <= '0;
      nic_data_in <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_start) begin
        grant       <= grant_next;
        nic_data_in <= grant_next ? c1_buf : c0_buf;
      end
      if (tx_state == T_ISSUE) begin
        rr_ptr   <= ~grant;
        hold_cnt <= '0;
      end else if (tx_state == T_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rx_next       = rx_state;
    rx_capture    = 1'b0;
    c0_valid_next = c0_rx_valid & ~c0_rx_ack;
    c1_valid_next = c1_rx_valid & ~c1_rx_ack;
    case (rx_state)
      R_IDLE: begin
        if (nic_rx_i) begin
          rx_capture = 1'b1;
          rx_next    = R_DELIVER;
        end
      end
      R_DELIVER: begin
        if (!c0_valid_next && !c1_valid_next) rx_next = R_WAIT;
      end
      R_WAIT:  rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // valids rise together with the captured byte; route is frozen for the byte in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= R_IDLE;
      rx_data     <= '0;
      route_q     <= 2'b00;
      c0_rx_valid <= 1'b0;
      c1_rx_valid <= 1'b0;
      nic_read    <= 1'b0;
      rx_drop_cnt <= 8'h00;
    end else begin
      rx_state <= rx_next;
      nic_read <= rx_capture;
      if (rx_capture) begin
        rx_data     <= nic_data_out;
        route_q     <= rx_route;
        c0_rx_valid <= rx_route[0];
        c1_rx_valid <= rx_route[1];
      end else begin
        c0_rx_valid <= c0_valid_next;
        c1_rx_valid <= c1_valid_next;
      end
      if (rx_state == R_DELIVER && route_q == 2'b00 && rx_drop_cnt != 8'hFF)
        rx_drop_cnt <= rx_drop_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_uart_nic_arbiter.sv
// tb/tb_uart_nic_arbiter.sv - directed and randomized checks of uart_nic_arbiter against a transaction-level model
module tb_uart_nic_arbiter;
  localparam int H = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         c0_wr, c1_wr;
  logic [W-1:0] c0_data, c1_data;
  logic         c0_busy, c1_busy, c0_ovf, c1_ovf;
  logic         c0_rx_valid, c1_rx_valid;
  logic [W-1:0] rx_data;
  logic         c0_rx_ack, c1_rx_ack;
  logic [1:0]   rx_route;
  logic [7:0]   rx_drop_cnt;
  logic [W-1:0] nic_data_in;
  logic         nic_write;
  logic         nic_tx_ready;
  logic [W-1:0] nic_data_out;
  logic         nic_rx_i;
  logic         nic_read;

  uart_nic_arbiter #(.TX_HOLDOFF(H), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .c0_wr(c0_wr), .c0_data(c0_data), .c0_busy(c0_busy), .c0_ovf(c0_ovf),
    .c1_wr(c1_wr), .c1_data(c1_data), .c1_busy(c1_busy), .c1_ovf(c1_ovf),
    .c0_rx_valid(c0_rx_valid), .c1_rx_valid(c1_rx_valid), .rx_data(rx_data),
    .c0_rx_ack(c0_rx_ack), .c1_rx_ack(c1_rx_ack), .rx_route(rx_route),
    .rx_drop_cnt(rx_drop_cnt), .nic_data_in(nic_data_in), .nic_write(nic_write),
    .nic_tx_ready(nic_tx_ready), .nic_data_out(nic_data_out), .nic_rx_i(nic_rx_i),
    .nic_read(nic_read)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_ok = 1'b0;

  // model state: buffer occupancy, arbitration, controller timing
  logic [1:0]   full_m, ovf_m, last_full, mv, last_route;
  logic [W-1:0] byte_m [2];
  logic [W-1:0] data_m, rdata_m, last_rx_byte;
  logic         rr_m, last_ready, last_rx_i, rx_busy_m;
  int           last_issue, free_at;
  int           drop_m;

  logic [W-1:0] rx_q[$];
  logic [W-1:0] tx_log_d[$];
  int           tx_log_c[$];
  int           rd_obs;
  bit           vseen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    full_m = 2'b00; ovf_m = 2'b00; mv = 2'b00;
    byte_m[0] = '0; byte_m[1] = '0;
    data_m = '0; rdata_m = '0;
    rr_m = 1'b0; rx_busy_m = 1'b0;
    last_full = 2'b00; last_ready = 1'b0; last_rx_i = 1'b0;
    last_route = 2'b00; last_rx_byte = '0;
    last_issue = cyc - 100; free_at = 0; drop_m = 0;
    rx_q.delete();
    model_ok = 1'b1;
  endtask

  // one clock cycle: entered and left at posedge+1
  task automatic step();
    logic [1:0] cur_full;
    logic       exp_w, exp_r;
    int         g;
    nic_rx_i     = (rx_q.size() > 0);
    nic_data_out = (rx_q.size() > 0) ? rx_q[0] : '0;
    cur_full = full_m;
    @(negedge clk);
    if (model_ok) begin
      chk("c0_busy", c0_busy, cur_full[0]);
      chk("c1_busy", c1_busy, cur_full[1]);
      chk("c0_ovf", c0_ovf, ovf_m[0]);
      chk("c1_ovf", c1_ovf, ovf_m[1]);
      exp_w = (cyc - 1 >= last_issue + H + 1) && last_ready && (last_full != 2'b00);
      chk("nic_write", nic_write, exp_w);
      if (exp_w) begin
        g = (last_full == 2'b11) ? int'(rr_m) : (last_full[1] ? 1 : 0);
        data_m = byte_m[g];
        full_m[g] = 1'b0;
        rr_m = (g == 0);
        last_issue = cyc;
      end
      chk("nic_data_in", nic_data_in, data_m);
      chk("rx_drop_cnt", rx_drop_cnt, drop_m);
      exp_r = !rx_busy_m && (cyc - 1 >= free_at) && last_rx_i;
      chk("nic_read", nic_read, exp_r);
      if (exp_r) begin
        rdata_m = last_rx_byte;
        mv = last_route;
        if (last_route == 2'b00 && drop_m < 255) drop_m++;
        rx_busy_m = 1'b1;
      end
      chk("c0_rx_valid", c0_rx_valid, mv[0]);
      chk("c1_rx_valid", c1_rx_valid, mv[1]);
      if (mv != 2'b00) chk("rx_data", rx_data, rdata_m);
      mv = mv & ~{c1_rx_ack, c0_rx_ack};
      if (rx_busy_m && mv == 2'b00) begin
        rx_busy_m = 1'b0;
        free_at = cyc + 2;
      end
      if (c0_wr) begin
        if (cur_full[0]) ovf_m[0] = 1'b1;
        else begin full_m[0] = 1'b1; byte_m[0] = c0_data; end
      end
      if (c1_wr) begin
        if (cur_full[1]) ovf_m[1] = 1'b1;
        else begin full_m[1] = 1'b1; byte_m[1] = c1_data; end
      end
    end
    if (nic_write === 1'b1) begin
      tx_log_d.push_back(nic_data_in);
      tx_log_c.push_back(cyc);
    end
    if (nic_read === 1'b1) begin
      rd_obs++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (c0_rx_valid === 1'b1 || c1_rx_valid === 1'b1) vseen = 1'b1;
    last_full = cur_full;
    last_ready = nic_tx_ready;
    last_rx_i = nic_rx_i;
    last_route = rx_route;
    last_rx_byte = nic_data_out;
    if (rst) model_reset();
    @(posedge clk);
    #1;
    cyc++;
    c0_wr = 1'b0; c1_wr = 1'b0;
    c0_rx_ack = 1'b0; c1_rx_ack = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c0_busy"}, c0_busy, 0);
    chk({tag, "_c1_busy"}, c1_busy, 0);
    chk({tag, "_c0_ovf"}, c0_ovf, 0);
    chk({tag, "_c1_ovf"}, c1_ovf, 0);
    chk({tag, "_c0_rx_valid"}, c0_rx_valid, 0);
    chk({tag, "_c1_rx_valid"}, c1_rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_drop_cnt"}, rx_drop_cnt, 0);
    chk({tag, "_nic_data_in"}, nic_data_in, 0);
    chk({tag, "_nic_write"}, nic_write, 0);
    chk({tag, "_nic_read"}, nic_read, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; c0_wr = 0; c1_wr = 0; c0_data = '0; c1_data = '0;
    c0_rx_ack = 0; c1_rx_ack = 0; rx_route = 2'b00; nic_tx_ready = 0;
    nic_data_out = '0; nic_rx_i = 0; rd_obs = 0; vseen = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk_all_zero("reset");

    // single TX
    nic_tx_ready = 1'b1;
    tx_log_d.delete(); tx_log_c.delete();
    k = cyc;
    c0_wr = 1'b1; c0_data = 8'h41;
    step();
    chk("single_busy", c0_busy, 1);
    steps(8);
    chk("single_count", tx_log_d.size(), 1);
    if (tx_log_d.size() >= 1) begin
      chk("single_data", tx_log_d[0], 8'h41);
      chk("single_latency", tx_log_c[0] - k, 2);
    end

    // contention from reset, then again with RR back at client 0, then client 1 alone
    do_reset();
    nic_tx_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      tx_log_d.delete(); tx_log_c.delete();
      c0_wr = 1'b1; c0_data = 8'h11;
      c1_wr = 1'b1; c1_data = 8'h22;
      steps(16);
      chk("cont_count", tx_log_d.size(), 2);
      if (tx_log_d.size() >= 2) begin
        chk("cont_first", tx_log_d[0], 8'h11);
        chk("cont_second", tx_log_d[1], 8'h22);
        chk("cont_gap", (tx_log_c[1] - tx_log_c[0]) >= H + 1, 1);
      end
    end
    tx_log_d.delete(); tx_log_c.delete();
    c1_wr = 1'b1; c1_data = 8'h22;
    steps(10);
    chk("c1_only_count", tx_log_d.size(), 1);
    if (tx_log_d.size() >= 1) chk("c1_only_data", tx_log_d[0], 8'h22);

    // overflow while controller is busy
    nic_tx_ready = 1'b0;
    c1_wr = 1'b1; c1_data = 8'h55;
    step();
    c1_wr = 1'b1; c1_data = 8'h66;
    step();
    chk("ovf_flag", c1_ovf, 1);
    chk("ovf_busy", c1_busy, 1);
    tx_log_d.delete(); tx_log_c.delete();
    nic_tx_ready = 1'b1;
    steps(12);
    chk("ovf_count", tx_log_d.size(), 1);
    if (tx_log_d.size() >= 1) chk("ovf_data", tx_log_d[0], 8'h55);
    chk("ovf_sticky", c1_ovf, 1);

    // RX broadcast
    rd_obs = 0;
    rx_route = 2'b11;
    rx_q.push_back(8'hA5);
    step();
    chk("bc_c0_valid", c0_rx_valid, 1);
    chk("bc_c1_valid", c1_rx_valid, 1);
    chk("bc_data", rx_data, 8'hA5);
    c0_rx_ack = 1'b1;
    step();
    chk("bc_reads", rd_obs, 1);
    chk("bc_c0_clear", c0_rx_valid, 0);
    chk("bc_c1_hold", c1_rx_valid, 1);
    steps(2);
    c1_rx_ack = 1'b1;
    step();
    chk("bc_c1_clear", c1_rx_valid, 0);
    steps(3);
    chk("bc_reads_final", rd_obs, 1);

    // RX drop with saturation
    rd_obs = 0; vseen = 0;
    rx_route = 2'b00;
    for (int i = 0; i < 300; i++) rx_q.push_back(8'(i));
    steps(960);
    chk("drop_reads", rd_obs, 300);
    chk("drop_cnt", rx_drop_cnt, 255);
    chk("drop_no_valid", vseen, 0);

    // reset during T_HOLD with c1 full and c0 RX pending
    do_reset();
    nic_tx_ready = 1'b1;
    tx_log_d.delete(); tx_log_c.delete();
    c0_wr = 1'b1; c0_data = 8'hAA;
    steps(3);
    chk("mid_issue", tx_log_d.size(), 1);
    c1_wr = 1'b1; c1_data = 8'hBB;
    rx_route = 2'b01;
    rx_q.push_back(8'h5C);
    step();
    chk("mid_c0_valid", c0_rx_valid, 1);
    chk("mid_c1_busy", c1_busy, 1);
    do_reset();
    chk_all_zero("midrst");
    steps(12);
    chk("mid_no_flushed_write", tx_log_d.size(), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      nic_tx_ready = ($urandom_range(0, 3) != 0);
      c0_wr = ($urandom_range(0, 5) == 0);
      c0_data = 8'($urandom_range(0, 255));
      c1_wr = ($urandom_range(0, 5) == 0);
      c1_data = 8'($urandom_range(0, 255));
      rx_route = 2'($urandom_range(0, 3));
      c0_rx_ack = ($urandom_range(0, 2) == 0);
      c1_rx_ack = ($urandom_range(0, 2) == 0);
      if (rx_q.size() < 3 && $urandom_range(0, 5) == 0) rx_q.push_back(8'($urandom_range(0, 255)));
      step();
    end
    nic_tx_ready = 1'b1;
    c0_rx_ack = 1'b1; c1_rx_ack = 1'b1;
    steps(20);
    chk("drain_c0", c0_busy, 0);
    chk("drain_c1", c1_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
